xc_malu_mdr_seq: RTL

//  Self-contained, parametrised iterative multiply/divide unit for the XCrypto MALU.

---
 rtl/xc_malu_mdr_seq.sv | 104 ++++++++++
 1 files changed

// File: rtl/xc_malu_mdr_seq.sv
// xc_malu_mdr_seq: iterative signed/unsigned/carry-less multiply and restoring divide with valid/ready handshake
module xc_malu_mdr_seq #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 2
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_hi,
  output logic [XLEN-1:0] rsp_lo,
  output logic            busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] N_MUL = CW'(XLEN / MUL_STEP);
  localparam logic [CW-1:0] N_DIV = CW'(XLEN);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic [XLEN-1:0] acc_hi, acc_lo, opnd, mag1, mag2, step_hi, step_lo;
  logic neg_hi, neg_lo, accept, req_div, div_zero, sgn1, sgn2, is_div, is_cl;
  logic [XLEN+MUL_STEP-1:0] ext, pp, msum;
  logic [XLEN:0] dsub;
  logic [2*XLEN-1:0] full, fix;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign rsp_valid = state == DONE;
  assign accept    = req_valid && req_ready && !flush;
  assign req_div   = req_op == 3'd4 || req_op == 3'd5;
  assign div_zero  = req_div && req_rs2 == '0;
  assign sgn1      = req_rs1[XLEN-1] && (req_op == 3'd0 || req_op == 3'd1 || req_op == 3'd4);
  assign sgn2      = req_rs2[XLEN-1] && (req_op == 3'd0 || req_op == 3'd4);
  assign mag1      = sgn1 ? -req_rs1 : req_rs1;
  assign mag2      = sgn2 ? -req_rs2 : req_rs2;
  assign is_div    = op == 3'd4 || op == 3'd5;
  assign is_cl     = op == 3'd3;
  assign ext       = {{MUL_STEP{1'b0}}, opnd};
  assign full      = {acc_hi, acc_lo};
  assign fix       = is_div ? {neg_hi ? -acc_hi : acc_hi, neg_lo ? -acc_lo : acc_lo}
                            : (neg_lo ? -full : full);
  // acc_hi holds the running high product / partial remainder; acc_lo shifts multiplier out or quotient in
  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_STEP; i++)
      if (acc_lo[i]) pp = is_cl ? pp ^ (ext << i) : pp + (ext << i);
    msum = is_cl ? ({{MUL_STEP{1'b0}}, acc_hi} ^ pp) : ({{MUL_STEP{1'b0}}, acc_hi} + pp);
    dsub = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opnd};
    step_hi = is_div ? (dsub[XLEN] ? {acc_hi[XLEN-2:0], acc_lo[XLEN-1]} : dsub[XLEN-1:0])
                     : msum[XLEN+MUL_STEP-1:MUL_STEP];
    step_lo = is_div ? {acc_lo[XLEN-2:0], ~dsub[XLEN]}
                     : {msum[MUL_STEP-1:0], acc_lo[XLEN-1:MUL_STEP]};
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = div_zero ? DONE : RUN;
      RUN:     if (cnt == CW'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      op     <= '0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      rsp_hi <= '0;
      rsp_lo <= '0;
    end else if (accept) begin
      op     <= req_op;
      cnt    <= req_div ? N_DIV : N_MUL;
      acc_hi <= '0;
      acc_lo <= req_div ? mag1 : mag2;
      opnd   <= req_div ? mag2 : mag1;
      neg_lo <= sgn1 ^ sgn2;
      neg_hi <= req_div ? sgn1 : sgn1 ^ sgn2;
      if (div_zero) begin
        rsp_hi <= req_rs1;
        rsp_lo <= '1;
      end
    end else if (state == RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt - CW'(1);
    end else if (state == FIX) begin
      {rsp_hi, rsp_lo} <= fix;
    end
endmodule
